icape2_responder: RTL
=====================

Name: icape2_responder

Overview:
- Cycle-accurate responder model of the 7-series ICAPE2 configuration port: the far end of our Wishbone-to-ICAPE2 bridge.
- Accepts the 32-bit CSIB/RDWRB/I word stream, hunts for the sync word and parses type-1 packet headers.
- Maintains a 32-entry configuration register file and returns read data on O.
- Synthesizable; substitutes for the ICAPE2 primitive in simulation and in FPGA-less bench targets so the bridge's read/write/IPROG sequences can be verified end to end.

Parameters:
- IDCODE, 32'h0362D093: value returned by read-only register 5'h0C.
- RD_LATENCY, 3: number of CS/R cycles (CSIB=0, RDWRB=1) after a read header before O holds the register value; 1..7.
- PIN_SWAP, 1: 1 means I/O are bit-reversed within each byte (ICAPE2 pin order); the block swaps internally. 0 means natural order.

Ports:
- i_clk  in  1  ICAP clock (the bridge's divided clock); all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cs_n  in  1  CSIB; 0 = port selected.
- i_rdwrn  in  1  RDWRB; 0 = write, 1 = read.
- i_data  in  32  I word.
- o_data  out  32  O word.
- o_synced  out  1  high while the sync word has been seen and no DESYNC has occurred since.
- o_iprog  out  1  one-cycle pulse on an IPROG command.
- o_wbstar  out  32  current contents of register 5'h10 (warm-boot start address).
- o_err  out  1  one-cycle pulse on a malformed or unsupported packet.

Behaviour:
- Word accepted: any cycle with i_cs_n=0 and i_rdwrn=0. Words are un-swapped first when PIN_SWAP=1. All state changes on accepted words only; i_cs_n=1 cycles are ignored.
- Reset values: state UNSYNC; o_data=32'hFFFFFFFF; o_synced=0; o_iprog=0; o_err=0; o_wbstar=0; register file all zero.
- UNSYNC:
  - Accepted 32'hAA995566 -> HDR, with o_synced=1 the next cycle.
  - Any other word is ignored; 32'hFFFFFFFF dummies are legal.
- HDR: decode the header.
  - [31:29]=3'b001 marks a type-1 header; [28:27]=op; [17:13]=addr; [12:0]=wc.
  - 32'h20000000 (NOOP) -> stay in HDR.
  - op=2'b10 (write) with wc=1 -> WDATA, latch addr.
  - op=2'b01 (read) with wc=1 -> RDPEND, latch addr.
  - Any other type/op/wc, including type-2 -> o_err pulse, stay in HDR.
- WDATA: the next accepted word is written to regfile[addr], then -> HDR. Addr-specific effects:
  - Addr 5'h0C (IDCODE) is read-only; the write is dropped without an error.
  - Addr 5'h04 (CMD), value 5'h0D (DESYNC) -> UNSYNC, o_synced=0 the next cycle.
  - Addr 5'h04, value 5'h0F (IPROG) -> o_iprog pulse, then UNSYNC.
  - Other CMD values are stored only.
- RDPEND:
  - Further CS/W words are NOOPs and are ignored.
  - Count consecutive CS/R cycles (i_cs_n=0, i_rdwrn=1). i_cs_n=1 cycles pause the count; they do not reset it.
  - On the RD_LATENCY-th CS/R cycle, o_data <= regfile[addr] (IDCODE for 5'h0C), registered, visible the following cycle, then -> HDR.
  - o_data holds until the next completed read or reset.
- Register 5'h10 is mirrored continuously on o_wbstar.
- o_iprog and o_err are cleared every cycle unless pulsed.
- Reset asserted mid-packet: returns to reset values immediately; partially received packets are discarded.
- A sync word arriving while already synced is treated as an invalid header: o_err pulse, still synced.

Optional Feature:
- Macro ICAPE2_RESPONDER_ABORT_EN.
- Defined: i_rdwrn toggling while i_cs_n stays 0, outside the RDPEND read window, is an abort:
  - o_err pulse;
  - state -> UNSYNC;
  - o_data <= 32'h0000009F (abort status) for one CS/R cycle, then 32'hFFFFFFFF.
- Undefined: RDWRB toggles while selected are ignored; only the accepted-word rules apply.

Test Plan:
- Write path: dummy, NOOP, sync, NOOP, NOOP, 32'h30020001, 32'h00400000, NOOP, NOOP, 32'h30008001, 32'h0000000D -> o_wbstar=32'h00400000 after the data word; o_synced 1 then 0 after DESYNC; o_err never asserted.
- Readback of 5'h10: after the write above, sync, header 32'h28020001, NOOPs, cs_n high one cycle, then 4 CS/R cycles -> o_data=32'h00400000 after the 3rd CS/R cycle. Repeat with 5'h0C -> o_data=IDCODE.
- IPROG: synced stream with 32'h30008001, 32'h0000000F -> o_iprog high exactly one cycle; o_synced=0 next cycle.
- Unsynced/malformed: 32'h30020001, 32'h12345678 with no sync -> o_wbstar unchanged at 0. Synced header 32'h30020002 (wc=2) -> o_err pulse, no write.
- Reset mid-read: assert i_reset after the read header and 1 CS/R cycle -> o_data=32'hFFFFFFFF, o_synced=0, subsequent CS/R cycles do not update o_data.
- Abort (ICAPE2_RESPONDER_ABORT_EN defined): while synced, cs_n=0 with rdwrn toggled 0->1 outside a read -> o_err pulse, o_data=32'h0000009F for one cycle, o_synced=0.

Source files
------------

// File: rtl/icape2_responder.sv
// icape2_responder: cycle-accurate ICAPE2 far-end model (sync hunt, type-1 packets, 32-entry regfile).
// Optional RDWRB-toggle abort detection is enabled by defining ICAPE2_RESPONDER_ABORT_EN.
module icape2_responder #(
    parameter logic [31:0] IDCODE     = 32'h0362D093,
    parameter int          RD_LATENCY = 3,
    parameter bit          PIN_SWAP   = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs_n,
    input  logic        i_rdwrn,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_synced,
    output logic        o_iprog,
    output logic [31:0] o_wbstar,
    output logic        o_err
);
    localparam logic [31:0] SYNC_WORD   = 32'hAA995566;
    localparam logic [31:0] NOOP_WORD   = 32'h20000000;
    localparam logic [31:0] ABORT_STAT  = 32'h0000009F;
    localparam logic [4:0]  ADDR_CMD    = 5'h04;
    localparam logic [4:0]  ADDR_IDCODE = 5'h0C;
    localparam logic [4:0]  ADDR_WBSTAR = 5'h10;
    localparam logic [4:0]  CMD_DESYNC  = 5'h0D;
    localparam logic [4:0]  CMD_IPROG   = 5'h0F;
    localparam logic [2:0]  LAST_RD     = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {S_UNSYNC, S_HDR, S_WDATA, S_RDPEND} state_t;

    state_t      state, state_next;
    logic [31:0] regfile [32];
    logic [31:0] word, data_q, rd_value;
    logic [4:0]  addr, addr_next;
    logic [2:0]  rd_count, rd_count_next;
    logic        word_ok, rd_cycle, wr_en, rd_fire, err_next, iprog_next, abort;

    // ICAPE2 pins carry each byte MSB-first relative to the logical word
    function automatic logic [31:0] bitrev_bytes(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
                r[8*b + k] = w[8*b + 7 - k];
        return r;
    endfunction

    assign word     = PIN_SWAP ? bitrev_bytes(i_data) : i_data;
    assign word_ok  = !i_cs_n && !i_rdwrn;
    assign rd_cycle = !i_cs_n && i_rdwrn;
    assign rd_value = (addr == ADDR_IDCODE) ? IDCODE : regfile[addr];
    assign o_data   = PIN_SWAP ? bitrev_bytes(data_q) : data_q;
    assign o_synced = (state != S_UNSYNC);
    assign o_wbstar = regfile[ADDR_WBSTAR];

`ifdef ICAPE2_RESPONDER_ABORT_EN
    logic prev_cs_n, prev_rdwrn, abort_hold;
    assign abort = !i_cs_n && !prev_cs_n && (i_rdwrn != prev_rdwrn) && (state != S_RDPEND);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        addr_next     = addr;
        rd_count_next = rd_count;
        wr_en         = 1'b0;
        rd_fire       = 1'b0;
        err_next      = 1'b0;
        iprog_next    = 1'b0;
        if (abort) begin
            state_next = S_UNSYNC;
            err_next   = 1'b1;
        end else begin
            case (state)
                S_UNSYNC: if (word_ok && word == SYNC_WORD) state_next = S_HDR;
                S_HDR: if (word_ok && word != NOOP_WORD) begin
                    if (word[31:29] == 3'b001 && word[12:0] == 13'd1 && word[28:27] == 2'b10) begin
                        state_next = S_WDATA;
                        addr_next  = word[17:13];
                    end else if (word[31:29] == 3'b001 && word[12:0] == 13'd1 && word[28:27] == 2'b01) begin
                        state_next    = S_RDPEND;
                        addr_next     = word[17:13];
                        rd_count_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                S_WDATA: if (word_ok) begin
                    wr_en      = (addr != ADDR_IDCODE);
                    state_next = S_HDR;
                    if (addr == ADDR_CMD && word[4:0] == CMD_DESYNC) state_next = S_UNSYNC;
                    if (addr == ADDR_CMD && word[4:0] == CMD_IPROG) begin
                        state_next = S_UNSYNC;
                        iprog_next = 1'b1;
                    end
                end
                // Deselected cycles pause the latency count without clearing it
                S_RDPEND: if (rd_cycle) begin
                    if (rd_count == LAST_RD) begin
                        rd_fire       = 1'b1;
                        state_next    = S_HDR;
                        rd_count_next = '0;
                    end else begin
                        rd_count_next = rd_count + 3'd1;
                    end
                end
                default: state_next = S_UNSYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_UNSYNC;
            addr     <= '0;
            rd_count <= '0;
            data_q   <= '1;
            o_iprog  <= 1'b0;
            o_err    <= 1'b0;
            for (int i = 0; i < 32; i++) regfile[i] <= '0;
`ifdef ICAPE2_RESPONDER_ABORT_EN
            prev_cs_n  <= 1'b1;
            prev_rdwrn <= 1'b1;
            abort_hold <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            rd_count <= rd_count_next;
            o_iprog  <= iprog_next;
            o_err    <= err_next;
            if (wr_en) regfile[addr] <= word;
`ifdef ICAPE2_RESPONDER_ABORT_EN
            prev_cs_n  <= i_cs_n;
            prev_rdwrn <= i_rdwrn;
            // Abort status is shown for one CS/R cycle, then the bus idles high
            if (abort) begin
                data_q     <= ABORT_STAT;
                abort_hold <= 1'b1;
            end else begin
                if (abort_hold && rd_cycle) begin
                    data_q     <= '1;
                    abort_hold <= 1'b0;
                end
                if (rd_fire) data_q <= rd_value;
            end
`else
            if (rd_fire) data_q <= rd_value;
`endif
        end
    end
endmodule
